// File: rtl/go_sequencer.sv
// ---------------------------------------------------------------------------
// go_sequencer
//
// Purpose
//   Drives three delay channels strictly in order: go_1, then go_2 once
//   done_1 is seen, then go_3 once done_2 is seen, and reports seq_done when
//   done_3 arrives. Each channel gets TIMEOUT cycles to answer. If a channel
//   is late, or the host aborts, the waited-on channel is killed and the
//   block clears the channel array's latched kill flag before returning to
//   idle.
//
// Handshakes
//   go_N / done_N : go_N is a one-cycle command. done_N is a level or pulse
//                   that is looked at only while channel N is the one being
//                   waited on. Done from any other channel is ignored.
//   kill_N / kill_ltchd / kill_clr : kill_N is a one-cycle command. The block
//                   then waits for kill_ltchd=1, pulses kill_clr for one
//                   cycle, and waits for kill_ltchd=0 before going idle.
//   start / abort : one-cycle or level requests. start is honoured only in
//                   IDLE. abort is honoured only in WAIT.
//
// Parameters
//   TIMEOUT     maximum WAIT cycles per channel (legal 2..255)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   start       run one go_1 -> go_2 -> go_3 sequence (IDLE only)
//   abort       kill the channel being waited on (WAIT only)
//   done_1..3   completion from channels 1..3
//   kill_ltchd  latched kill status from the channel array
//   go_1..3     one-cycle go pulses
//   kill_1..3   one-cycle kill pulses
//   kill_clr    one-cycle clear of kill_ltchd
//   busy        high from accepted start until back in IDLE
//   seq_done    one-cycle pulse on successful completion
//   timeout_err sticky timeout flag, cleared on accepted start
//   err_chan    channel of last timeout/abort kill (0 = none)
//   dbg_state   current FSM state (0 IDLE, 1 WAIT, 2 KILL, 3 CLR)
// ---------------------------------------------------------------------------
module go_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       done_1,
  input  logic       done_2,
  input  logic       done_3,
  input  logic       kill_ltchd,
  output logic       go_1,
  output logic       go_2,
  output logic       go_3,
  output logic       kill_1,
  output logic       kill_2,
  output logic       kill_3,
  output logic       kill_clr,
  output logic       busy,
  output logic       seq_done,
  output logic       timeout_err,
  output logic [1:0] err_chan,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_KILL = 2'd2,
    S_CLR  = 2'd3
  } state_t;

  // Last timer value that is still a legal wait cycle; the timeout fires
  // when this value is reached without a done from the active channel.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_t     r_state;
  logic [1:0] r_ch;
  logic [7:0] r_timer;
  logic [2:0] r_go;
  logic [2:0] r_kill;
  logic       r_kill_clr;
  logic       r_busy;
  logic       r_seq_done;
  logic       r_timeout_err;
  logic [1:0] r_err_chan;

  // -------------------------------------------------------------------------
  // Next-state / next-output wires
  // -------------------------------------------------------------------------
  state_t     w_state_nxt;
  logic [1:0] w_ch_nxt;
  logic [7:0] w_timer_nxt;
  logic [2:0] w_go_nxt;
  logic [2:0] w_kill_nxt;
  logic       w_kill_clr_nxt;
  logic       w_busy_nxt;
  logic       w_seq_done_nxt;
  logic       w_timeout_err_nxt;
  logic [1:0] w_err_chan_nxt;

  // Decoded events in the current cycle
  logic       w_in_wait;
  logic       w_done_ch;
  logic       w_timeout;
  logic       w_abort_acc;
  logic       w_last_ch;
  logic [2:0] w_ch_onehot;
  logic [2:0] w_next_onehot;

  // Only the channel being waited on can complete the current step.
  always_comb begin
    w_done_ch = 1'b0;
    case (r_ch)
      2'd1:    w_done_ch = done_1;
      2'd2:    w_done_ch = done_2;
      2'd3:    w_done_ch = done_3;
      default: w_done_ch = 1'b0;
    endcase
  end

  // Priority inside WAIT: done beats timeout, timeout beats abort. A done
  // arriving in the very cycle the timer expires still counts as success.
  assign w_in_wait   = (r_state == S_WAIT);
  assign w_timeout   = w_in_wait && !w_done_ch && (r_timer == TMO_LAST);
  assign w_abort_acc = w_in_wait && !w_done_ch && !w_timeout && abort;
  assign w_last_ch   = (r_ch == 2'd3);

  // One-hot selectors for the active channel and the one after it.
  always_comb begin
    w_ch_onehot   = 3'b000;
    w_next_onehot = 3'b000;
    case (r_ch)
      2'd1: begin
        w_ch_onehot   = 3'b001;
        w_next_onehot = 3'b010;
      end
      2'd2: begin
        w_ch_onehot   = 3'b010;
        w_next_onehot = 3'b100;
      end
      2'd3: begin
        w_ch_onehot   = 3'b100;
        w_next_onehot = 3'b000;
      end
      default: begin
        w_ch_onehot   = 3'b000;
        w_next_onehot = 3'b000;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Process 1: state and output registers
  // -------------------------------------------------------------------------
  // A reset in any state drops everything immediately; no kill or kill_clr
  // is issued for an abandoned sequence.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_ch          <= 2'd1;
      r_timer       <= 8'd0;
      r_go          <= 3'b000;
      r_kill        <= 3'b000;
      r_kill_clr    <= 1'b0;
      r_busy        <= 1'b0;
      r_seq_done    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_err_chan    <= 2'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_ch          <= w_ch_nxt;
      r_timer       <= w_timer_nxt;
      r_go          <= w_go_nxt;
      r_kill        <= w_kill_nxt;
      r_kill_clr    <= w_kill_clr_nxt;
      r_busy        <= w_busy_nxt;
      r_seq_done    <= w_seq_done_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_err_chan    <= w_err_chan_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Process 2: next state, active channel and wait timer
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_timer_nxt = r_timer;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_WAIT;
          w_ch_nxt    = 2'd1;
          w_timer_nxt = 8'd0;
        end
      end
      S_WAIT: begin
        if (w_done_ch) begin
          w_timer_nxt = 8'd0;
          if (w_last_ch) begin
            w_state_nxt = S_IDLE;
            w_ch_nxt    = 2'd1;
          end else begin
            w_ch_nxt    = r_ch + 2'd1;
          end
        end else if (w_timeout || w_abort_acc) begin
          // ch is kept so err_chan/kill stay tied to the killed channel.
          w_state_nxt = S_KILL;
          w_timer_nxt = 8'd0;
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      S_KILL: begin
        if (kill_ltchd) begin
          w_state_nxt = S_CLR;
        end
      end
      S_CLR: begin
        if (!kill_ltchd) begin
          w_state_nxt = S_IDLE;
          w_ch_nxt    = 2'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ch_nxt    = 2'd1;
        w_timer_nxt = 8'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Process 3: next values of the registered outputs
  // -------------------------------------------------------------------------
  // Pulses default low so each one lasts exactly one cycle; status outputs
  // default to holding.
  always_comb begin
    w_go_nxt          = 3'b000;
    w_kill_nxt        = 3'b000;
    w_kill_clr_nxt    = 1'b0;
    w_seq_done_nxt    = 1'b0;
    w_busy_nxt        = r_busy;
    w_timeout_err_nxt = r_timeout_err;
    w_err_chan_nxt    = r_err_chan;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_go_nxt          = 3'b001;
          w_busy_nxt        = 1'b1;
          w_timeout_err_nxt = 1'b0;
          w_err_chan_nxt    = 2'd0;
        end
      end
      S_WAIT: begin
        if (w_done_ch) begin
          if (w_last_ch) begin
            w_seq_done_nxt = 1'b1;
            w_busy_nxt     = 1'b0;
          end else begin
            w_go_nxt       = w_next_onehot;
          end
        end else if (w_timeout) begin
          w_kill_nxt        = w_ch_onehot;
          w_timeout_err_nxt = 1'b1;
          w_err_chan_nxt    = r_ch;
        end else if (w_abort_acc) begin
          w_kill_nxt     = w_ch_onehot;
          w_err_chan_nxt = r_ch;
        end
      end
      S_KILL: begin
        if (kill_ltchd) begin
          w_kill_clr_nxt = 1'b1;
        end
      end
      S_CLR: begin
        if (!kill_ltchd) begin
          w_busy_nxt = 1'b0;
        end
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output mapping
  // -------------------------------------------------------------------------
  assign go_1        = r_go[0];
  assign go_2        = r_go[1];
  assign go_3        = r_go[2];
  assign kill_1      = r_kill[0];
  assign kill_2      = r_kill[1];
  assign kill_3      = r_kill[2];
  assign kill_clr    = r_kill_clr;
  assign busy        = r_busy;
  assign seq_done    = r_seq_done;
  assign timeout_err = r_timeout_err;
  assign err_chan    = r_err_chan;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_go_sequencer.sv
// ---------------------------------------------------------------------------
// tb_go_sequencer
//
// Two instances share one set of inputs: dut_a with the default TIMEOUT=16
// and dut_b with TIMEOUT=4. Each directed scenario checks only the instance
// it is written for; both are reset between scenarios. Every check compares
// a packed snapshot of all outputs against a hand-computed vector:
//   {state[1:0], err_chan[1:0], timeout_err, seq_done, busy, kill_clr,
//    kill_3, kill_2, kill_1, go_3, go_2, go_1}
// Inputs change #1 after a rising edge; outputs are sampled at that point.
// ---------------------------------------------------------------------------
module tb_go_sequencer;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset      = 1'b0;
  logic start      = 1'b0;
  logic abort      = 1'b0;
  logic done_1     = 1'b0;
  logic done_2     = 1'b0;
  logic done_3     = 1'b0;
  logic kill_ltchd = 1'b0;

  logic       a_go_1, a_go_2, a_go_3, a_kill_1, a_kill_2, a_kill_3;
  logic       a_kill_clr, a_busy, a_seq_done, a_timeout_err;
  logic [1:0] a_err_chan, a_dbg_state;
  logic       b_go_1, b_go_2, b_go_3, b_kill_1, b_kill_2, b_kill_3;
  logic       b_kill_clr, b_busy, b_seq_done, b_timeout_err;
  logic [1:0] b_err_chan, b_dbg_state;

  go_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .done_1(done_1), .done_2(done_2), .done_3(done_3), .kill_ltchd(kill_ltchd),
    .go_1(a_go_1), .go_2(a_go_2), .go_3(a_go_3),
    .kill_1(a_kill_1), .kill_2(a_kill_2), .kill_3(a_kill_3),
    .kill_clr(a_kill_clr), .busy(a_busy), .seq_done(a_seq_done),
    .timeout_err(a_timeout_err), .err_chan(a_err_chan), .dbg_state(a_dbg_state)
  );

  go_sequencer #(.TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .done_1(done_1), .done_2(done_2), .done_3(done_3), .kill_ltchd(kill_ltchd),
    .go_1(b_go_1), .go_2(b_go_2), .go_3(b_go_3),
    .kill_1(b_kill_1), .kill_2(b_kill_2), .kill_3(b_kill_3),
    .kill_clr(b_kill_clr), .busy(b_busy), .seq_done(b_seq_done),
    .timeout_err(b_timeout_err), .err_chan(b_err_chan), .dbg_state(b_dbg_state)
  );

  logic [13:0] obs_a, obs_b;
  assign obs_a = {a_dbg_state, a_err_chan, a_timeout_err, a_seq_done, a_busy,
                  a_kill_clr, a_kill_3, a_kill_2, a_kill_1, a_go_3, a_go_2, a_go_1};
  assign obs_b = {b_dbg_state, b_err_chan, b_timeout_err, b_seq_done, b_busy,
                  b_kill_clr, b_kill_3, b_kill_2, b_kill_1, b_go_3, b_go_2, b_go_1};

  // Expected-vector builder and state codes
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, KILL = 2'd2, CLR = 2'd3;

  function automatic logic [13:0] mk(input logic [1:0] st, input logic [1:0] ec,
                                     input logic te, input logic sd, input logic bz,
                                     input logic kc, input logic [2:0] kl,
                                     input logic [2:0] gv);
    return {st, ec, te, sd, bz, kc, kl, gv};
  endfunction

  // -------------------------------------------------------------------------
  // Driver tasks / checker
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    start = 0; abort = 0; done_1 = 0; done_2 = 0; done_3 = 0; kill_ltchd = 0;
    reset = 0;
    step();
    step();
    reset = 1;
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    // ---- Reset, with start held across reset release ----
    start = 1; reset = 0;
    step();
    chk("rst_a", obs_a, mk(IDLE, 0, 0, 0, 0, 0, 3'b000, 3'b000));
    chk("rst_b", obs_b, mk(IDLE, 0, 0, 0, 0, 0, 3'b000, 3'b000));
    reset = 1;

    // ---- Nominal on dut_a: done_1 +3, done_2 +5, done_3 +2 ----
    step();  // E0: first edge with reset high samples start
    chk("nom_go1", obs_a, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b001));
    start = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("nom_wait1", obs_a, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b000));
    end
    done_1 = 1;
    step();  // E4
    chk("nom_go2", obs_a, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b010));
    done_1 = 0;
    for (int i = 5; i <= 9; i++) begin
      step();
      chk("nom_wait2", obs_a, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b000));
    end
    done_2 = 1;
    step();  // E10
    chk("nom_go3", obs_a, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b100));
    done_2 = 0;
    for (int i = 11; i <= 12; i++) begin
      step();
      chk("nom_wait3", obs_a, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b000));
    end
    done_3 = 1;
    step();  // E13
    chk("nom_seq_done", obs_a, mk(IDLE, 0, 0, 1, 0, 0, 3'b000, 3'b000));
    done_3 = 0;
    start = 1;  // back-to-back with seq_done
    step();
    chk("b2b_go1", obs_a, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b001));
    start = 0;

    // ---- Timeout on dut_b (TIMEOUT=4), done_2 never arrives ----
    do_reset();
    chk("rst2_b", obs_b, mk(IDLE, 0, 0, 0, 0, 0, 3'b000, 3'b000));
    start = 1;
    step();
    chk("to_go1", obs_b, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b001));
    start = 0; done_1 = 1;
    step();
    chk("to_go2", obs_b, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b010));
    done_1 = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_wait2", obs_b, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b000));
    end
    step();  // 4 cycles after go_2
    chk("to_kill2", obs_b, mk(KILL, 2, 1, 0, 1, 0, 3'b010, 3'b000));
    step();
    chk("to_kill_hold", obs_b, mk(KILL, 2, 1, 0, 1, 0, 3'b000, 3'b000));
    kill_ltchd = 1;
    step();
    chk("to_kill_clr", obs_b, mk(CLR, 2, 1, 0, 1, 1, 3'b000, 3'b000));
    step();
    chk("to_clr_hold", obs_b, mk(CLR, 2, 1, 0, 1, 0, 3'b000, 3'b000));
    kill_ltchd = 0;
    step();
    chk("to_idle", obs_b, mk(IDLE, 2, 1, 0, 0, 0, 3'b000, 3'b000));
    start = 1;
    step();
    chk("to_restart_clr", obs_b, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b001));
    start = 0;

    // ---- Abort on dut_a in 2nd WAIT cycle of channel 3 ----
    do_reset();
    start = 1;
    step();
    chk("ab_go1", obs_a, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b001));
    start = 0; done_1 = 1;
    step();
    chk("ab_go2", obs_a, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b010));
    done_1 = 0; done_2 = 1;
    step();
    chk("ab_go3", obs_a, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b100));
    done_2 = 0;
    step();
    chk("ab_wait3", obs_a, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b000));
    abort = 1;
    step();
    chk("ab_kill3", obs_a, mk(KILL, 3, 0, 0, 1, 0, 3'b100, 3'b000));
    abort = 0; kill_ltchd = 1;
    step();
    chk("ab_kill_clr", obs_a, mk(CLR, 3, 0, 0, 1, 1, 3'b000, 3'b000));
    kill_ltchd = 0;
    step();
    chk("ab_idle", obs_a, mk(IDLE, 3, 0, 0, 0, 0, 3'b000, 3'b000));

    // ---- Races on dut_b: done vs timeout, done vs abort ----
    do_reset();
    start = 1;
    step();
    chk("rc_go1", obs_b, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b001));
    start = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rc_wait1", obs_b, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b000));
    end
    step();
    chk("rc_wait1_last", obs_b, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b000));
    done_1 = 1;  // arrives in the timer-expiry cycle
    step();
    chk("rc_done_vs_to", obs_b, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b010));
    done_1 = 0; done_2 = 1; abort = 1;
    step();
    chk("rc_done_vs_abort", obs_b, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b100));
    done_2 = 0; abort = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rc_wait3", obs_b, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b000));
    end
    step();
    chk("rc_kill3_to", obs_b, mk(KILL, 3, 1, 0, 1, 0, 3'b100, 3'b000));

    // ---- Ignored inputs on dut_a, then reset while in KILL ----
    do_reset();
    abort = 1;
    step();
    chk("ig_abort_idle", obs_a, mk(IDLE, 0, 0, 0, 0, 0, 3'b000, 3'b000));
    abort = 0; start = 1;
    step();
    chk("ig_go1", obs_a, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b001));
    done_2 = 1; done_3 = 1;  // start still high while busy
    for (int i = 0; i < 2; i++) begin
      step();
      chk("ig_wrong_done", obs_a, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b000));
    end
    start = 0; done_2 = 0; done_3 = 0; done_1 = 1;
    step();
    chk("ig_go2", obs_a, mk(WAIT, 0, 0, 0, 1, 0, 3'b000, 3'b010));
    done_1 = 0; abort = 1;
    step();
    chk("ig_kill2", obs_a, mk(KILL, 2, 0, 0, 1, 0, 3'b010, 3'b000));
    abort = 0; kill_ltchd = 1; reset = 0;
    step();
    chk("ig_rst_in_kill", obs_a, mk(IDLE, 0, 0, 0, 0, 0, 3'b000, 3'b000));
    reset = 1;
    step();
    chk("ig_no_kill_clr", obs_a, mk(IDLE, 0, 0, 0, 0, 0, 3'b000, 3'b000));
    kill_ltchd = 0;

    // ---- Report ----
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
